// File: rtl/int_pend_arb_pkg.sv
// Shared types and helpers for the interrupt pending/arbitration stage.
// Holds the FSM state encoding, default sizing and the priority encoder.
package int_pend_arb_pkg;

  localparam int NSRC_DEF = 5;
  localparam int VW_DEF   = 3;
  localparam int PE_MAXW  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKW = 2'd2
  } arb_state_t;

  // Index of the lowest set bit; source 0 has the highest priority.
  function automatic int prio_enc(input logic [PE_MAXW-1:0] v);
    int idx;
    idx = 0;
    for (int i = PE_MAXW - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_pend_bit.sv
// One clocked pending bit with clear-dominant set/clear semantics,
// matching the upstream set/clear latches.
module int_pend_bit (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic pend
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= ~clr & (set | pend);
  end

endmodule

// File: rtl/int_pend_arb.sv
// Pending capture, masking and fixed-priority selection of interrupt sources,
// presented to the core over a req/ack handshake with auto-clear on ack.
module int_pend_arb
  import int_pend_arb_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int VW   = VW_DEF
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_set,
  input  logic            clr_wr,
  input  logic [NSRC-1:0] clr_din,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_din,
  input  logic            int_ack,
  output logic            int_req,
  output logic [VW-1:0]   int_vec,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] mask
);

  arb_state_t      state_reg;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] autoclr;
  logic [NSRC-1:0] vec_onehot;
  logic [VW-1:0]   sel;
  logic            ack_take;
  logic            vec_active;

  assign active     = pend & mask;
  assign sel        = VW'(prio_enc(PE_MAXW'(active)));
  assign ack_take   = (state_reg == ST_REQ) && int_ack;
  assign vec_active = |(active & vec_onehot);

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign vec_onehot[gi] = (int_vec == VW'(gi));
      // Auto-clear lasts only for the REQ cycle in which ack is seen.
      assign autoclr[gi]    = ack_take && vec_onehot[gi];
      assign clr[gi]        = (clr_wr & clr_din[gi]) | autoclr[gi];

      int_pend_bit u_bit (
        .clk  (sys_clk),
        .rst  (reset),
        .set  (src_set[gi]),
        .clr  (clr[gi]),
        .pend (pend[gi])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      int_req   <= 1'b0;
      int_vec   <= '0;
      mask      <= '0;
    end else begin
      if (mask_wr) mask <= mask_din;
      case (state_reg)
        ST_IDLE: begin
          if (|active) begin
            int_vec   <= sel;
            int_req   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        // int_vec stays frozen here: no preemption by higher priority.
        ST_REQ: begin
          if (int_ack) begin
            int_req   <= 1'b0;
            state_reg <= ST_ACKW;
          end else if (!vec_active) begin
            int_req   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_ACKW: begin
          if (!int_ack) state_reg <= ST_IDLE;
        end
        default: begin
          int_req   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_pend_arb.sv
// Scoreboard bench for int_pend_arb: a behavioural model predicts outputs
// after each clock edge, and a negedge monitor compares them to the DUT.
module tb_int_pend_arb;

  localparam int NSRC = 5;
  localparam int VW   = 3;

  logic            sys_clk = 1'b0;
  logic            reset   = 1'b1;
  logic [NSRC-1:0] src_set = '0;
  logic            clr_wr  = 1'b0;
  logic [NSRC-1:0] clr_din = '0;
  logic            mask_wr = 1'b0;
  logic [NSRC-1:0] mask_din = '0;
  logic            int_ack = 1'b0;
  logic            int_req;
  logic [VW-1:0]   int_vec;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;

  int_pend_arb #(.NSRC(NSRC), .VW(VW)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .src_set  (src_set),
    .clr_wr   (clr_wr),
    .clr_din  (clr_din),
    .mask_wr  (mask_wr),
    .mask_din (mask_din),
    .int_ack  (int_ack),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .pend     (pend),
    .mask     (mask)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic            req;
    logic [VW-1:0]   vec;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    int              cyc;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int n_reqs   = 0;

  // Reference model: a request is either outstanding, waiting for ack
  // release, or absent; pending/mask bits kept as plain arrays.
  bit m_req;
  bit m_ackwait;
  int m_vec;
  bit m_pend [NSRC];
  bit m_mask [NSRC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_no, act, exp_v);
    end
  endtask

  function automatic logic [NSRC-1:0] pack(input bit a [NSRC]);
    logic [NSRC-1:0] v;
    for (int i = 0; i < NSRC; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    snap_t s;
    int    kill;
    bit    act [NSRC];
    bit    any;
    if (reset) begin
      m_req = 0; m_ackwait = 0; m_vec = 0;
      for (int i = 0; i < NSRC; i++) begin m_pend[i] = 0; m_mask[i] = 0; end
    end else begin
      kill = -1;
      any  = 0;
      for (int i = 0; i < NSRC; i++) begin
        act[i] = m_pend[i] && m_mask[i];
        any    = any || act[i];
      end
      if (m_req) begin
        if (int_ack) begin
          kill = m_vec; m_req = 0; m_ackwait = 1;
        end else if (!act[m_vec]) begin
          m_req = 0;
        end
      end else if (m_ackwait) begin
        if (!int_ack) m_ackwait = 0;
      end else if (any) begin
        for (int i = NSRC - 1; i >= 0; i--) if (act[i]) m_vec = i;
        m_req = 1;
        n_reqs++;
      end
      for (int i = 0; i < NSRC; i++) begin
        if ((clr_wr && clr_din[i]) || i == kill) m_pend[i] = 0;
        else if (src_set[i])                     m_pend[i] = 1;
      end
      if (mask_wr) for (int i = 0; i < NSRC; i++) m_mask[i] = mask_din[i];
    end
    s.req  = m_req;
    s.vec  = VW'(m_vec);
    s.pend = pack(m_pend);
    s.mask = pack(m_mask);
    s.cyc  = cyc_no;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      cyc_no++;
      model_step();
      #1;
    end
  endtask

  task automatic wait_req(input int maxc);
    int c;
    c = 0;
    while (!m_req && c < maxc) begin cyc(); c++; end
    if (!m_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_req timeout at cycle %0d: got req=0, expected req=1", cyc_no);
    end
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1; cyc();
    int_ack = 1'b0; cyc();
  endtask

  always @(negedge sys_clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("int_req", 32'(int_req), 32'(s.req));
      check("int_vec", 32'(int_vec), 32'(s.vec));
      check("pend",    32'(pend),    32'(s.pend));
      check("mask",    32'(mask),    32'(s.mask));
    end
  end

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(6);

    // Single source, basic handshake.
    mask_din = 5'b11111; mask_wr = 1'b1; cyc(); mask_wr = 1'b0;
    src_set = 5'b00100; cyc(); src_set = '0;
    wait_req(5); cyc(1);
    ack_pulse(); cyc(3);

    // Priority without preemption, then back-to-back request.
    src_set = 5'b01000; cyc(); src_set = '0;
    wait_req(5);
    src_set = 5'b00010; cyc(); src_set = '0; cyc(2);
    ack_pulse();
    wait_req(5); ack_pulse(); cyc(3);

    // Mask gating.
    mask_din = '0; mask_wr = 1'b1; cyc(); mask_wr = 1'b0;
    src_set = 5'b00001; cyc(); src_set = '0; cyc(4);
    mask_din = 5'b00001; mask_wr = 1'b1; cyc(); mask_wr = 1'b0;
    wait_req(5); ack_pulse();
    mask_din = 5'b11111; mask_wr = 1'b1; cyc(); mask_wr = 1'b0; cyc(2);

    // Withdraw by software clear.
    src_set = 5'b10000; cyc(); src_set = '0;
    wait_req(5); cyc();
    clr_wr = 1'b1; clr_din = 5'b10000; cyc(); clr_wr = 1'b0; clr_din = '0; cyc(3);

    // Set colliding with auto-clear: dropped, then held.
    src_set = 5'b00100; wait_req(5); cyc();
    int_ack = 1'b1; cyc(); int_ack = 1'b0; src_set = '0; cyc(4);
    src_set = 5'b00100; wait_req(5);
    int_ack = 1'b1; cyc(); int_ack = 1'b0; cyc(2);
    wait_req(5); src_set = '0; ack_pulse(); cyc(3);

    // Async reset mid-handshake.
    src_set = 5'b01000; cyc(); src_set = '0;
    wait_req(5); cyc();
    @(negedge sys_clk); #2;
    reset = 1'b1; #1;
    check("async_rst_int_req", 32'(int_req), 32'd0);
    check("async_rst_pend",    32'(pend),    32'd0);
    check("async_rst_mask",    32'(mask),    32'd0);
    cyc(2);
    reset = 1'b0;
    mask_din = 5'b11111; mask_wr = 1'b1; cyc(); mask_wr = 1'b0;

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      src_set  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      clr_wr   = ($urandom_range(0, 9) == 0);
      clr_din  = NSRC'($urandom);
      mask_wr  = ($urandom_range(0, 24) == 0);
      mask_din = NSRC'($urandom) | NSRC'($urandom);
      if (m_req)          int_ack = ($urandom_range(0, 2) == 0);
      else if (m_ackwait) int_ack = ($urandom_range(0, 1) == 0);
      else                int_ack = ($urandom_range(0, 7) == 0);
      cyc();
    end
    src_set = '0; clr_wr = 1'b0; mask_wr = 1'b0; int_ack = 1'b0;
    cyc(4);
    @(negedge sys_clk); #1;
    if (n_reqs < 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL request_count: got %0d requests, expected at least 20", n_reqs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_pend_arb.md
Name: int_pend_arb

Overview:
- Event-capture and arbitration stage directly downstream of the Tom set/clear pending latches.
- Holds one clocked pending bit per interrupt source with the same clear-dominant set/clear semantics as those latches, masks the bits, and priority-selects one source.
- Presents the selected source to the GPU core with a req/ack handshake, then auto-clears that source's pending bit.
- Software clear and mask writes arrive from the GPU register decode.

Parameters:
- NSRC, 5, number of interrupt sources (source 0 = highest priority).
- VW, 3, vector width; must satisfy 2**VW >= NSRC.

Ports:
- sys_clk  in  1  single system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_set  in  NSRC  per-source set request; level-sampled each cycle.
- clr_wr  in  1  software write-1-to-clear strobe.
- clr_din  in  NSRC  bits to clear when clr_wr=1.
- mask_wr  in  1  mask register write strobe.
- mask_din  in  NSRC  new enable mask (1 = enabled).
- int_ack  in  1  core acknowledge, level.
- int_req  out  1  interrupt request to the core.
- int_vec  out  VW  index of the requested source; valid while int_req=1.
- pend  out  NSRC  raw pending bits, readable unmasked.
- mask  out  NSRC  current mask register.

Behaviour:
- Reset values: pend=0, mask=0, int_req=0, int_vec=0, FSM=IDLE.
- Pending bit update, per source i, each cycle: pend_next[i] = ~clr[i] & (src_set[i] | pend[i]). Clear dominates set.
- clr[i] = (clr_wr & clr_din[i]) | autoclr[i].
- mask updates on mask_wr, taking effect the next cycle.
- active = pend & mask. sel = lowest index set in active.
- FSM states and transitions:
  - IDLE: if active != 0, latch int_vec=sel, int_req=1, go to REQ. Latency: src_set high in cycle N gives pend=1 at N+1 and int_req=1 at N+2.
  - REQ:
    - If int_ack=1: assert autoclr[int_vec] for exactly this cycle, drop int_req next cycle, go to ACKW.
    - Else if active[int_vec]=0 (software clear or mask removed): withdraw, int_req=0 next cycle, go to IDLE.
    - int_vec is frozen in REQ; a newly pending higher-priority source does not preempt.
  - ACKW: int_req=0; wait for int_ack=0, then go to IDLE. No new request is issued while ack is still high.
- Simultaneous events:
  - src_set[i] in the same cycle as autoclr[i]: the bit ends cleared. This event is lost by design, matching latch semantics.
  - Software clear of a different bit than int_vec does not disturb the handshake.
- Back-to-back: the minimum request-to-request spacing is 3 cycles (REQ, ACKW, IDLE).
- Reset asserted mid-handshake: all state is cleared immediately (async). int_req drops without waiting for ack.
- NSRC < 2**VW: int_vec never exceeds NSRC-1.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, REQ, ACKW; 2-bit encoding).
  - default NSRC/VW constants.
  - a priority-encode function.
- One natural sub-module: int_pend_bit. It is the clear-dominant clocked set/clear pending bit with async active-high reset, instantiated NSRC times.
- The FSM and arbitration stay in the top.

Test Plan:
1. Reset release, mask=5'b11111, pulse src_set=5'b00100 at cycle 10:
   - pend=00100 at 11; int_req=1, int_vec=2 at 12.
   - ack at 14: pend=0 and int_req=0 at 15; IDLE once ack drops.
2. Priority and no-preempt:
   - pend=01000, int_req up with vec=3; then set src 1 before ack.
   - vec stays 3 until ack; next request is vec=1, 3 cycles after the prior one.
3. Mask gating:
   - mask=0, set src 0: pend=00001, int_req stays 0.
   - Write mask=00001: int_req=1, vec=0 two cycles after the write.
4. Withdraw: in REQ for vec=4, clr_wr with clr_din=10000 → int_req=0 next cycle, FSM=IDLE, no ack needed.
5. Collision:
   - src_set[2] held high during the ack cycle for vec=2 → pend[2]=0 after that cycle (clear wins).
   - If src_set[2] stays high, a fresh request for vec=2 follows.
6. Async reset asserted mid-cycle while int_req=1 and ack pending → int_req, pend, mask go to 0 immediately, without waiting for a clock edge.
